cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_controller.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller
//   Multi-cycle control FSM for a small 13-bit-address CPU. It fetches an
//   instruction, decodes the 3-bit opcode, starts the ALU, resolves
//   branches/stores, writes back and counts retired instructions. Memory
//   accesses are guarded by a timeout that drops the machine into FAULT.
//
// Ports
//   clk             system clock, all state changes on the rising edge
//   reset           synchronous active-high reset
//   start           begin execution from PC=0 (honoured only in IDLE)
//   Opcode[2:0]     decoded opcode from the datapath
//   memDone         memory access complete (FETCH / MEM_WRITE only)
//   branchFlag      ALU compare result, 1 = branch taken
//   branchAddress   branch target from the ALU
//   PC[12:0]        program counter to the datapath memory
//   read/write      memory read / write strobes
//   instruction     instruction-space select
//   instructionType 1 = R-type (RegData3), 0 = sign-extended immediate
//   ALU_Op[2:0]     ALU operation select
//   ALUSTART        one-cycle ALU start pulse
//   regWrite        one-cycle register-file write enable
//   halted/fault    sticky HALT / memory-timeout indicators
//   instr_count     retired instruction count, saturating at 16'hFFFF

module cpu_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  Opcode,
  input  logic        memDone,
  input  logic        branchFlag,
  input  logic [12:0] branchAddress,
  output logic [12:0] PC,
  output logic        read,
  output logic        write,
  output logic        instruction,
  output logic        instructionType,
  output logic [2:0]  ALU_Op,
  output logic        ALUSTART,
  output logic        regWrite,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] EXECUTE   = 4'd3;
  localparam logic [3:0] RESOLVE   = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] WRITEBACK = 4'd6;
  localparam logic [3:0] HALTED    = 4'd7;
  localparam logic [3:0] FAULT     = 4'd8;

  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  // Value of the waiting-cycle counter during the last cycle allowed to
  // wait; a miss on that cycle means MEM_TIMEOUT cycles have elapsed.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [12:0]   pc_q, pc_d;
  logic [15:0]   count_q, count_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [2:0]    aluOp_q, aluOp_d;
  logic          instType_q, instType_d;
  logic          retire;

  // Next-state logic. The timeout counter is cleared on every transition
  // into FETCH or MEM_WRITE and counts cycles spent waiting for memDone.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    timeout_d  = timeout_q;
    opcode_d   = opcode_q;
    aluOp_d    = aluOp_q;
    instType_d = instType_q;
    retire     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          pc_d      = '0;
          timeout_d = '0;
        end
      end
      FETCH: begin
        if (memDone) begin
          state_d = DECODE;
        end else if (timeout_q == TIMEOUT_LAST) begin
          state_d = FAULT;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      DECODE: begin
        opcode_d = Opcode;
        // Opcodes 000-011 are R-type and pass straight through as ALU_Op.
        case (Opcode)
          OP_ADDI:  begin aluOp_d = 3'b000; instType_d = 1'b0; end
          OP_BEQ:   begin aluOp_d = 3'b101; instType_d = 1'b1; end
          OP_STORE: begin aluOp_d = 3'b000; instType_d = 1'b0; end
          OP_HALT:  begin aluOp_d = 3'b000; instType_d = 1'b0; end
          default:  begin aluOp_d = Opcode; instType_d = 1'b1; end
        endcase
        state_d = (Opcode == OP_HALT) ? HALTED : EXECUTE;
      end
      EXECUTE: begin
        state_d = RESOLVE;
      end
      RESOLVE: begin
        case (opcode_q)
          OP_BEQ: begin
            pc_d      = branchFlag ? branchAddress : pc_q + 13'd1;
            retire    = 1'b1;
            state_d   = FETCH;
            timeout_d = '0;
          end
          OP_STORE: begin
            state_d   = MEM_WRITE;
            timeout_d = '0;
          end
          default: begin
            state_d = WRITEBACK;
          end
        endcase
      end
      MEM_WRITE: begin
        if (memDone) begin
          pc_d      = pc_q + 13'd1;
          retire    = 1'b1;
          state_d   = FETCH;
          timeout_d = '0;
        end else if (timeout_q == TIMEOUT_LAST) begin
          state_d = FAULT;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      WRITEBACK: begin
        pc_d      = pc_q + 13'd1;
        retire    = 1'b1;
        state_d   = FETCH;
        timeout_d = '0;
      end
      HALTED: state_d = HALTED;
      FAULT:  state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Saturating retire counter.
  always_comb begin
    count_d = count_q;
    if (retire && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      timeout_q  <= '0;
      opcode_q   <= '0;
      aluOp_q    <= '0;
      instType_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      opcode_q   <= opcode_d;
      aluOp_q    <= aluOp_d;
      instType_q <= instType_d;
    end
  end

  // Strobes are decoded from the state register only, so read and write are
  // mutually exclusive and ALUSTART/regWrite last exactly one cycle.
  logic aluActive;
  always_comb begin
    aluActive = (state_q == EXECUTE) || (state_q == RESOLVE) ||
                (state_q == MEM_WRITE) || (state_q == WRITEBACK);
  end

  assign PC              = pc_q;
  assign read            = (state_q == FETCH);
  assign instruction     = (state_q == FETCH);
  assign write           = (state_q == MEM_WRITE);
  assign ALUSTART        = (state_q == EXECUTE);
  assign regWrite        = (state_q == WRITEBACK);
  assign halted          = (state_q == HALTED);
  assign fault           = (state_q == FAULT);
  assign ALU_Op          = aluActive ? aluOp_q : 3'b000;
  assign instructionType = aluActive ? instType_q : 1'b0;
  assign instr_count     = count_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
//   Directed testbench for cpu_controller. Inputs change 1ns after a rising
//   edge and outputs are sampled at the same point, so every value seen is
//   the settled result of the previous edge.

module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  Opcode;
  logic        memDone;
  logic        branchFlag;
  logic [12:0] branchAddress;
  logic [12:0] PC;
  logic        read;
  logic        write;
  logic        instruction;
  logic        instructionType;
  logic [2:0]  ALU_Op;
  logic        ALUSTART;
  logic        regWrite;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int testsRun  = 0;
  int failCount = 0;

  cpu_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Opcode(Opcode),
    .memDone(memDone),
    .branchFlag(branchFlag),
    .branchAddress(branchAddress),
    .PC(PC),
    .read(read),
    .write(write),
    .instruction(instruction),
    .instructionType(instructionType),
    .ALU_Op(ALU_Op),
    .ALUSTART(ALUSTART),
    .regWrite(regWrite),
    .halted(halted),
    .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one non-memory ALU instruction starting in FETCH, ending in FETCH.
  task automatic aluInstr(input logic [2:0] op, input logic [2:0] expAluOp,
                          input logic expType);
    Opcode  = op;
    memDone = 1'b1;
    applyStimulus();
    memDone = 1'b0;
    applyStimulus();
    checkOutput("alu_start", ALUSTART, 1'b1);
    checkOutput("alu_op", ALU_Op, expAluOp);
    checkOutput("alu_type", instructionType, expType);
    applyStimulus();
    applyStimulus();
    checkOutput("alu_regwrite", regWrite, 1'b1);
    applyStimulus();
    checkOutput("alu_regwrite_off", regWrite, 1'b0);
  endtask

  // Runs one BEQ starting in FETCH, ending in FETCH.
  task automatic branchInstr(input logic flag, input logic [12:0] target);
    Opcode        = 3'b101;
    branchFlag    = flag;
    branchAddress = target;
    memDone       = 1'b1;
    applyStimulus();
    memDone = 1'b0;
    applyStimulus();
    checkOutput("beq_op", ALU_Op, 3'b101);
    applyStimulus();
    applyStimulus();
    checkOutput("beq_regwrite", regWrite, 1'b0);
    checkOutput("beq_fetch", read, 1'b1);
  endtask

  // Directed sequence: each block below leaves the DUT in a known state
  // for the next one, with PC and instr_count tracked by hand.
  initial begin
    int writeCycles;
    int readSeen;

    reset         = 1'b1;
    start         = 1'b0;
    Opcode        = 3'b000;
    memDone       = 1'b0;
    branchFlag    = 1'b0;
    branchAddress = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_pc", PC, 13'd0);
    checkOutput("rst_read", read, 1'b0);
    checkOutput("rst_count", instr_count, 16'd0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    reset = 1'b0;
    applyStimulus();
    checkOutput("idle_read", read, 1'b0);

    // ADD with single-cycle fetch.
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("fetch_read", read, 1'b1);
    checkOutput("fetch_instr", instruction, 1'b1);
    checkOutput("fetch_write", write, 1'b0);
    Opcode  = 3'b000;
    memDone = 1'b1;
    applyStimulus();
    memDone = 1'b0;
    checkOutput("decode_read", read, 1'b0);
    checkOutput("decode_alustart", ALUSTART, 1'b0);
    applyStimulus();
    checkOutput("add_alustart", ALUSTART, 1'b1);
    checkOutput("add_aluop", ALU_Op, 3'b000);
    checkOutput("add_type", instructionType, 1'b1);
    applyStimulus();
    checkOutput("add_alustart_off", ALUSTART, 1'b0);
    checkOutput("add_aluop_hold", ALU_Op, 3'b000);
    applyStimulus();
    checkOutput("add_regwrite", regWrite, 1'b1);
    checkOutput("add_pc_before", PC, 13'd0);
    applyStimulus();
    checkOutput("add_regwrite_off", regWrite, 1'b0);
    checkOutput("add_pc", PC, 13'd1);
    checkOutput("add_count", instr_count, 16'd1);

    // SUB, AND, OR.
    aluInstr(3'b001, 3'b001, 1'b1);
    aluInstr(3'b010, 3'b010, 1'b1);
    aluInstr(3'b011, 3'b011, 1'b1);
    checkOutput("rtype_pc", PC, 13'd4);
    checkOutput("rtype_count", instr_count, 16'd4);

    // BEQ taken, then taken to 5, then not taken from 5.
    branchInstr(1'b1, 13'h0040);
    checkOutput("beq_taken_pc", PC, 13'h0040);
    checkOutput("beq_taken_count", instr_count, 16'd5);
    branchInstr(1'b1, 13'd5);
    checkOutput("beq_to5_pc", PC, 13'd5);
    branchInstr(1'b0, 13'h0040);
    checkOutput("beq_not_taken_pc", PC, 13'd6);
    checkOutput("beq_not_taken_count", instr_count, 16'd7);

    // STORE with memDone arriving in the 4th MEM_WRITE cycle.
    Opcode  = 3'b110;
    memDone = 1'b1;
    applyStimulus();
    memDone = 1'b0;
    applyStimulus();
    checkOutput("store_aluop", ALU_Op, 3'b000);
    checkOutput("store_type", instructionType, 1'b0);
    applyStimulus();
    checkOutput("store_resolve_write", write, 1'b0);
    applyStimulus();
    writeCycles = 0;
    readSeen    = 0;
    for (int i = 0; i < 4; i++) begin
      if (write) writeCycles++;
      if (read) readSeen++;
      if (i == 3) memDone = 1'b1;
      applyStimulus();
      memDone = 1'b0;
    end
    checkOutput("store_write_cycles", writeCycles, 32'd4);
    checkOutput("store_read_seen", readSeen, 32'd0);
    checkOutput("store_write_off", write, 1'b0);
    checkOutput("store_pc", PC, 13'd7);
    checkOutput("store_count", instr_count, 16'd8);

    // Branch to the top of the address space, then ADDI wraps PC to 0.
    branchInstr(1'b1, 13'h1FFF);
    checkOutput("top_pc", PC, 13'h1FFF);
    aluInstr(3'b100, 3'b000, 1'b0);
    checkOutput("wrap_pc", PC, 13'd0);
    checkOutput("wrap_count", instr_count, 16'd10);

    // HALT: no retire, sticky, start ignored.
    Opcode  = 3'b111;
    memDone = 1'b1;
    applyStimulus();
    memDone = 1'b0;
    applyStimulus();
    checkOutput("halt_halted", halted, 1'b1);
    checkOutput("halt_count", instr_count, 16'd10);
    checkOutput("halt_alustart", ALUSTART, 1'b0);
    start = 1'b1;
    applyStimulus();
    applyStimulus();
    start = 1'b0;
    checkOutput("halt_sticky", halted, 1'b1);
    checkOutput("halt_read", read, 1'b0);

    // Fetch timeout: 16 waiting cycles then FAULT.
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("rst2_halted", halted, 1'b0);
    checkOutput("rst2_count", instr_count, 16'd0);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus();
    checkOutput("to_cycle16_read", read, 1'b1);
    checkOutput("to_cycle16_fault", fault, 1'b0);
    applyStimulus();
    checkOutput("to_fault", fault, 1'b1);
    checkOutput("to_read", read, 1'b0);
    memDone = 1'b1;
    start   = 1'b1;
    applyStimulus();
    applyStimulus();
    memDone = 1'b0;
    start   = 1'b0;
    checkOutput("to_fault_sticky", fault, 1'b1);

    // Reset in MEM_WRITE together with memDone.
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    aluInstr(3'b001, 3'b001, 1'b1);
    checkOutput("mw_pre_count", instr_count, 16'd1);
    Opcode  = 3'b110;
    memDone = 1'b1;
    applyStimulus();
    memDone = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("mw_write", write, 1'b1);
    applyStimulus();
    reset   = 1'b1;
    memDone = 1'b1;
    applyStimulus();
    reset   = 1'b0;
    memDone = 1'b0;
    checkOutput("mw_rst_write", write, 1'b0);
    checkOutput("mw_rst_pc", PC, 13'd0);
    checkOutput("mw_rst_count", instr_count, 16'd0);
    applyStimulus();
    checkOutput("mw_rst_idle_read", read, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
